// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
//   state_t : controller FSM states
//   NIB_W   : width of the shared carry-lookahead slice
package nibble_serial_adder_ctrl_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
// Ports:
//   x, y : 4-bit addends
//   cin  : carry in
//   sum  : 4-bit sum
//   cout : carry out of bit 3
module cla4_slice
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    assign g = x & y;
    assign p = x ^ y;

    // Every carry is a flat sum-of-products of generate/propagate terms.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[NIB_W-1:0];
    assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract built by iterating one 4-bit lookahead slice over
// WIDTH/4 cycles, with valid/ready handshakes on operands and result.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready combinational)
//   in_x, in_y, in_sub  : operands; in_sub=1 selects x - y
//   out_valid/out_ready : result handshake
//   out_sum, out_cout   : result and carry out (borrow-free flag on subtract)
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int unsigned NIBS  = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int unsigned LSB_W = IDX_W + 2;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             load;

    logic [LSB_W-1:0] lsb;
    logic [NIB_W-1:0] slice_sum;
    logic             slice_cout;

    // Bit offset of the nibble handled this pass.
    assign lsb = LSB_W'(idx_q) << 2;

    cla4_slice u_slice (
        .x    (x_q[lsb +: NIB_W]),
        .y    (y_q[lsb +: NIB_W]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        x_d      = x_q;
        y_d      = y_q;
        in_ready = 1'b0;
        load     = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            RUN: begin
                sum_d[lsb +: NIB_W] = slice_sum;
                carry_d             = slice_cout;
                if (idx_q == IDX_W'(NIBS - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                // Result drain and next accept share the same cycle.
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Subtract is x + ~y + 1: invert y once at capture, seed carry with 1.
        if (load) begin
            x_d     = in_x;
            y_d     = in_y ^ {WIDTH{in_sub}};
            carry_d = in_sub;
            idx_d   = '0;
            state_d = RUN;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned W    = 16;
    localparam int unsigned NIBS = W / 4;
    localparam int unsigned NOPS = 1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int total = 0;
    int bad   = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic, returns {cout, sum}.
    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sub);
        int unsigned r;
        if (!sub) begin
            r = int'(x) + int'(y);
            return {(r >= 65536), W'(r)};
        end
        r = (int'(x) + 65536 - int'(y)) % 65536;
        return {(x >= y), W'(r)};
    endfunction

    // Present one operand pair from IDLE with out_ready=1 and check the result.
    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sub, input logic [W-1:0] esum, input logic ecout);
        int n;
        out_ready = 1'b1;
        in_x = x; in_y = y; in_sub = sub; in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_x = W'($urandom); in_y = W'($urandom); in_sub = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(NIBS));
        check({tag, "_sum"}, 32'(out_sum), 32'(esum));
        check({tag, "_cout"}, 32'(out_cout), 32'(ecout));
        step();
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [W:0]   q[$];
        logic [W:0]   e;
        logic [W-1:0] held;
        int           n;
        int           sent;
        int           got;
        int           cyc;
        logic         acc;
        logic         take;

        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_sub = 1'b0; out_ready = 1'b0;
        step(); step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        rst_n = 1'b1;
        step();

        do_op("add_small", 16'h0001, 16'h0003, 1'b0, 16'h0004, 1'b0);
        do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        do_op("sub_pos", 16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b1);
        do_op("sub_neg", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0);

        // Backpressure: hold result in DONE while inputs churn.
        out_ready = 1'b0;
        in_x = 16'h0A0B; in_y = 16'h0101; in_sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("bp_latency", 32'(n), 32'(NIBS));
        held = out_sum;
        check("bp_sum", 32'(held), 32'h0B0C);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom); in_x = W'($urandom); in_y = W'($urandom);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            check("bp_stable", 32'(out_sum), 32'(held));
        end
        check("bp_still_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1; in_valid = 1'b1; in_x = 16'h00F0; in_y = 16'h0010; in_sub = 1'b0;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("b2b_out_valid", 32'(out_valid), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("b2b_latency", 32'(n), 32'(NIBS));
        check("b2b_sum", 32'(out_sum), 32'h0100);
        check("b2b_cout", 32'(out_cout), 32'd0);
        step();

        // Reset during the third RUN cycle.
        in_x = 16'hFFFF; in_y = 16'hFFFF; in_sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum", 32'(out_sum), 32'd0);
        check("midrst_out_cout", 32'(out_cout), 32'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) n++;
            step();
        end
        check("midrst_no_partial", 32'(n), 32'd0);

        // Random traffic with stalls on both sides, in-order scoreboard.
        sent = 0; got = 0; cyc = 0;
        while (got < int'(NOPS) && cyc < 40000) begin
            out_ready = ($urandom_range(3) != 0);
            if (!in_valid && sent < int'(NOPS) && $urandom_range(2) != 0) begin
                in_x = W'($urandom); in_y = W'($urandom); in_sub = 1'($urandom);
                in_valid = 1'b1;
            end
            #1;
            acc  = in_valid && in_ready;
            take = out_valid && out_ready;
            if (take) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("rnd_sum", 32'(out_sum), 32'(e[W-1:0]));
                    check("rnd_cout", 32'(out_cout), 32'(e[W]));
                end
                got++;
            end
            if (acc) begin
                q.push_back(ref_op(in_x, in_y, in_sub));
                sent++;
            end
            step();
            if (acc) begin
                in_valid = 1'b0;
                in_x = W'($urandom); in_y = W'($urandom); in_sub = 1'($urandom);
            end
            cyc++;
        end
        check("rnd_sent", 32'(sent), 32'(NOPS));
        check("rnd_got", 32'(got), 32'(NOPS));
        check("rnd_queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
